// File: rtl/montacargas_pkg.sv
// Shared constants for the freight-elevator display path: segment patterns,
// floor codes and ring-counter select values.
package montacargas_pkg;

    // Segment patterns, {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_1       = 7'b1111001;
    localparam logic [6:0] SEG_2       = 7'b0100100;
    localparam logic [6:0] SEG_3       = 7'b0110000;
    localparam logic [6:0] SEG_GUION   = 7'b0111111;
    localparam logic [6:0] SEG_SUBE    = 7'b1100011;
    localparam logic [6:0] SEG_BAJA    = 7'b0100001;
    localparam logic [6:0] SEG_ABIERTA = 7'b0001000;
    localparam logic [6:0] SEG_APAGADO = 7'b1111111;

    localparam logic [1:0] PISO_NINGUNO = 2'd0;
    localparam logic [1:0] PISO_1       = 2'd1;
    localparam logic [1:0] PISO_2       = 2'd2;
    localparam logic [1:0] PISO_3       = 2'd3;

    localparam logic [2:0] SEL_P1 = 3'b100;
    localparam logic [2:0] SEL_P2 = 3'b010;
    localparam logic [2:0] SEL_P3 = 3'b001;

    function automatic logic [6:0] seg_digito(input logic [1:0] piso);
        case (piso)
            PISO_1:  return SEG_1;
            PISO_2:  return SEG_2;
            PISO_3:  return SEG_3;
            default: return SEG_GUION;
        endcase
    endfunction

endpackage

// File: rtl/generador_parpadeo.sv
// Blink phase generator for the destination display; restarts visible on
// every rising edge of the motion flag.
module generador_parpadeo
    import montacargas_pkg::*;
#(
    parameter int BLINK_HALF = 38
) (
    input  logic clockInt_150Hz,
    input  logic reset,
    input  logic enMovimiento,
    output logic fase_visible
);

    localparam int W = $clog2(BLINK_HALF + 1);
    localparam logic [W-1:0] ULTIMO = W'(BLINK_HALF - 1);

    logic [W-1:0] cuenta, cuenta_sig;
    logic         fase, fase_sig;
    logic         enMovimiento_q;
    logic         flanco;

    always_comb begin
        flanco     = enMovimiento && !enMovimiento_q;
        cuenta_sig = cuenta + 1'b1;
        fase_sig   = fase;
        if (flanco) begin
            cuenta_sig = '0;
            fase_sig   = 1'b1;
        end else if (cuenta == ULTIMO) begin
            cuenta_sig = '0;
            fase_sig   = ~fase;
        end
    end

    always_ff @(posedge clockInt_150Hz or negedge reset) begin
        if (!reset) begin
            cuenta         <= '0;
            fase           <= 1'b1;
            enMovimiento_q <= 1'b0;
        end else begin
            cuenta         <= cuenta_sig;
            fase           <= fase_sig;
            enMovimiento_q <= enMovimiento;
        end
    end

    // The display register loads alongside the phase, so it sees the phase
    // being entered this edge; the restart edge is therefore always visible.
    assign fase_visible = fase_sig;

endmodule

// File: rtl/display_floor_driver.sv
// Drives one floor display per ring-counter tick: active-low anode enable and
// the shared 7-segment bus, both registered.
module display_floor_driver
    import montacargas_pkg::*;
#(
    parameter int BLINK_HALF = 38
) (
    input  logic       clockInt_150Hz,
    input  logic       reset,
    input  logic [2:0] cuentaAnillo,
    input  logic [1:0] pisoActual,
    input  logic [1:0] pisoDestino,
    input  logic       enMovimiento,
    input  logic       puertaAbierta,
    output logic [2:0] anodos,
    output logic [6:0] segmentos
);

    logic       fase_visible;
    logic [1:0] piso_sel;
    logic       sel_valida;
    logic [2:0] anodos_sig;
    logic [6:0] segmentos_sig;

    generador_parpadeo #(.BLINK_HALF(BLINK_HALF)) u_parpadeo (
        .clockInt_150Hz(clockInt_150Hz),
        .reset         (reset),
        .enMovimiento  (enMovimiento),
        .fase_visible  (fase_visible)
    );

    always_comb begin
        piso_sel   = PISO_NINGUNO;
        sel_valida = 1'b1;
        case (cuentaAnillo)
            SEL_P1:  piso_sel = PISO_1;
            SEL_P2:  piso_sel = PISO_2;
            SEL_P3:  piso_sel = PISO_3;
            default: sel_valida = 1'b0;
        endcase
    end

    // First matching rule wins; the order below is the display priority.
    always_comb begin
        anodos_sig    = 3'b111;
        segmentos_sig = SEG_GUION;
        if (!sel_valida) begin
            segmentos_sig = SEG_APAGADO;
        end else begin
            anodos_sig = ~cuentaAnillo;
            if (pisoActual == PISO_NINGUNO) begin
                segmentos_sig = SEG_GUION;
            end else if (enMovimiento && piso_sel == pisoActual) begin
                if (pisoDestino > pisoActual)
                    segmentos_sig = SEG_SUBE;
                else if (pisoDestino != PISO_NINGUNO && pisoDestino < pisoActual)
                    segmentos_sig = SEG_BAJA;
                else
                    segmentos_sig = SEG_GUION;
            end else if (enMovimiento && piso_sel == pisoDestino) begin
                segmentos_sig = fase_visible ? seg_digito(piso_sel) : SEG_APAGADO;
            end else if (!enMovimiento && piso_sel == pisoActual) begin
                segmentos_sig = puertaAbierta ? SEG_ABIERTA : seg_digito(piso_sel);
            end
        end
    end

    always_ff @(posedge clockInt_150Hz or negedge reset) begin
        if (!reset) begin
            anodos    <= 3'b111;
            segmentos <= SEG_APAGADO;
        end else begin
            anodos    <= anodos_sig;
            segmentos <= segmentos_sig;
        end
    end

endmodule

// File: tb/tb_display_floor_driver.sv
// Bench for display_floor_driver: directed scenarios plus random traffic,
// checked against a rule-level model of the floor displays.
module tb_display_floor_driver;

    localparam int BLINK_HALF = 38;

    localparam logic [6:0] E_1     = 7'b1111001;
    localparam logic [6:0] E_2     = 7'b0100100;
    localparam logic [6:0] E_3     = 7'b0110000;
    localparam logic [6:0] E_GUION = 7'b0111111;
    localparam logic [6:0] E_U     = 7'b1100011;
    localparam logic [6:0] E_D     = 7'b0100001;
    localparam logic [6:0] E_A     = 7'b0001000;
    localparam logic [6:0] E_OFF   = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] sel;
    logic [1:0] pa, pd;
    logic       mov, door;
    logic [2:0] anodos;
    logic [6:0] segmentos;

    int checks = 0;
    int errors = 0;

    // model state
    int         blink_n;
    logic       mov_prev;
    logic       vis;
    logic [2:0] exp_an;
    logic [6:0] exp_seg;

    display_floor_driver #(.BLINK_HALF(BLINK_HALF)) dut (
        .clockInt_150Hz(clk),
        .reset         (rst_n),
        .cuentaAnillo  (sel),
        .pisoActual    (pa),
        .pisoDestino   (pd),
        .enMovimiento  (mov),
        .puertaAbierta (door),
        .anodos        (anodos),
        .segmentos     (segmentos)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] digit(input int k);
        if (k == 1) return E_1;
        if (k == 2) return E_2;
        return E_3;
    endfunction

    function automatic logic [9:0] model_out(input logic [2:0] s, input int a, input int d,
                                             input logic m, input logic o, input logic v);
        int k;
        logic [6:0] g;
        if (s == 3'b100) k = 1;
        else if (s == 3'b010) k = 2;
        else if (s == 3'b001) k = 3;
        else return {3'b111, E_OFF};
        if (a == 0) g = E_GUION;
        else if (m && k == a) g = (d > a) ? E_U : ((d > 0 && d < a) ? E_D : E_GUION);
        else if (m && k == d) g = v ? digit(k) : E_OFF;
        else if (!m && k == a) g = o ? E_A : digit(k);
        else g = E_GUION;
        return {~s, g};
    endfunction

    function automatic logic [2:0] ring(input int i);
        case (i % 3)
            0:       return 3'b100;
            1:       return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

    // One clock edge; the model absorbs the inputs seen at that edge and the
    // caller compares at the following falling edge.
    task automatic tick();
        @(posedge clk);
        if (mov && !mov_prev) blink_n = 0;
        else blink_n++;
        mov_prev = mov;
        vis = ((blink_n / BLINK_HALF) % 2) == 0;
        {exp_an, exp_seg} = model_out(sel, int'(pa), int'(pd), mov, door, vis);
        @(negedge clk);
    endtask

    task automatic model_reset();
        blink_n  = 0;
        mov_prev = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sel = 3'b100; pa = 2'd1; pd = 2'd0; mov = 1'b0; door = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (anodos !== 3'b111 || segmentos !== E_OFF) begin
            errors++;
            $display("FAIL reset_hold: anodos=%b segmentos=%b required 111 1111111", anodos, segmentos);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (anodos !== 3'b011 || segmentos !== E_1) begin
            errors++;
            $display("FAIL reset_release: anodos=%b segmentos=%b required 011 1111001", anodos, segmentos);
        end
        sel = 3'b010; tick();
        @(posedge clk); #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (anodos !== 3'b111 || segmentos !== E_OFF) begin
            errors++;
            $display("FAIL reset_async: anodos=%b segmentos=%b required 111 1111111", anodos, segmentos);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sel = 3'b100;
        tick();
        checks++;
        if (anodos !== exp_an || segmentos !== exp_seg) begin
            errors++;
            $display("FAIL reset_reload: anodos=%b segmentos=%b required %b %b", anodos, segmentos, exp_an, exp_seg);
        end
    endtask

    task automatic test_stopped_door_open();
        logic [6:0] req_seg [3];
        logic [2:0] req_an  [3];
        req_seg[0] = E_GUION; req_seg[1] = E_A;    req_seg[2] = E_GUION;
        req_an[0]  = 3'b011;  req_an[1]  = 3'b101; req_an[2]  = 3'b110;
        pa = 2'd2; pd = 2'd0; mov = 1'b0; door = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sel = ring(i);
            tick();
            checks++;
            if (anodos !== req_an[i] || segmentos !== req_seg[i]) begin
                errors++;
                $display("FAIL door_open[%0d]: anodos=%b segmentos=%b required %b %b",
                         i, anodos, segmentos, req_an[i], req_seg[i]);
            end
        end
        door = 1'b0;
    endtask

    task automatic test_moving_up();
        logic [6:0] req;
        pa = 2'd1; pd = 2'd3; mov = 1'b0; door = 1'b0; sel = 3'b100;
        tick();
        mov = 1'b1;
        for (int i = 0; i < 170; i++) begin
            sel = ring(i + 1);
            tick();
            if (sel == 3'b001) req = ((i % 76) < 38) ? E_3 : E_OFF;
            else if (sel == 3'b100) req = E_U;
            else req = E_GUION;
            checks++;
            if (segmentos !== req || anodos !== ~sel) begin
                errors++;
                $display("FAIL moving_up[%0d]: anodos=%b segmentos=%b required %b %b",
                         i, anodos, segmentos, ~sel, req);
            end
        end
    endtask

    task automatic test_moving_down_restart();
        bit found = 0;
        pa = 2'd3; pd = 2'd1; mov = 1'b1; door = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            sel = ring(i);
            tick();
            checks++;
            if (anodos !== exp_an || segmentos !== exp_seg) begin
                errors++;
                $display("FAIL moving_down[%0d]: anodos=%b segmentos=%b required %b %b",
                         i, anodos, segmentos, exp_an, exp_seg);
            end
            if (sel == 3'b001 && segmentos !== E_D) begin
                errors++;
                $display("FAIL down_symbol[%0d]: segmentos=%b required %b", i, segmentos, E_D);
            end
            if (!vis && sel == 3'b100) found = 1;
        end
        checks++;
        if (!found || segmentos !== E_OFF) begin
            errors++;
            $display("FAIL down_blank: found=%0d segmentos=%b required 1111111", found, segmentos);
        end
        mov = 1'b0; sel = 3'b010; tick();
        mov = 1'b1; sel = 3'b100; tick();
        checks++;
        if (anodos !== 3'b011 || segmentos !== E_1) begin
            errors++;
            $display("FAIL blink_restart: anodos=%b segmentos=%b required 011 1111001", anodos, segmentos);
        end
    endtask

    task automatic test_invalid_unknown();
        logic [2:0] bad [4];
        bad[0] = 3'b000; bad[1] = 3'b110; bad[2] = 3'b111; bad[3] = 3'b011;
        pa = 2'd2; pd = 2'd3; mov = 1'b0; door = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sel = bad[i];
            tick();
            checks++;
            if (anodos !== 3'b111 || segmentos !== E_OFF) begin
                errors++;
                $display("FAIL invalid_sel %b: anodos=%b segmentos=%b required 111 1111111",
                         bad[i], anodos, segmentos);
            end
        end
        pa = 2'd0;
        for (int i = 0; i < 6; i++) begin
            sel = ring(i); pd = 2'($urandom_range(0, 3)); mov = 1'($urandom_range(0, 1));
            door = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (anodos !== ~sel || segmentos !== E_GUION) begin
                errors++;
                $display("FAIL unknown_floor[%0d]: anodos=%b segmentos=%b required %b 0111111",
                         i, anodos, segmentos, ~sel);
            end
        end
    endtask

    task automatic test_direction_fallback();
        pa = 2'd2; pd = 2'd0; mov = 1'b1; door = 1'b0;
        for (int i = 0; i < 90; i++) begin
            sel = ring(i);
            tick();
            checks++;
            if (anodos !== ~sel || segmentos !== E_GUION) begin
                errors++;
                $display("FAIL fallback[%0d]: anodos=%b segmentos=%b required %b 0111111",
                         i, anodos, segmentos, ~sel);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            sel = ($urandom_range(0, 9) < 8) ? ring($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            pa = 2'($urandom_range(0, 3));
            pd = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) mov = ~mov;
            door = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (anodos !== exp_an || segmentos !== exp_seg) begin
                errors++;
                $display("FAIL random[%0d]: anodos=%b segmentos=%b required %b %b",
                         i, anodos, segmentos, exp_an, exp_seg);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stopped_door_open();
        test_moving_up();
        test_moving_down_restart();
        test_invalid_unknown();
        test_direction_fallback();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
